l2_mem_responder: RTL and testbench

- Memory-side responder for the L2 cache's word-serial memory port (mem_r/mem_w/mem_addr/mem_data_out in, mem_data/mem_ready out).
- Models main memory: a word-addressed synchronous RAM with a programmable access latency.
- Serves single-word reads and writes. The cache moves a 128-bit line as four sequential word transactions.
- Sits between the L2 cache and the top-level/board memory. It is also used as the bench memory model for cache verification.

---
 rtl/l2_mem_responder_pkg.sv | 14 +
 rtl/mem_ram_sp.sv | 27 ++
 rtl/l2_mem_responder.sv | 105 ++++++++++
 tb/tb_l2_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_responder_pkg.sv
// Shared constants for the L2 memory-side responder.
// FSM state encoding and word/line geometry shared with the L2 cache.
package l2_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int WORD_SHIFT = 2;
  localparam int LINE_WORDS = 4;

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous 32-bit RAM: registered read, write enable.
// Ports: clk, rst (async low, clears read reg), we, re, addr, wdata, rdata.
module mem_ram_sp #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/l2_mem_responder.sv
// Word-serial main-memory model for the L2 cache with programmable latency.
// Ports: clk, rst (async low), mem_r/mem_w/mem_addr/mem_data_out in;
//        mem_data, mem_ready, busy out.
module l2_mem_responder
  import l2_mem_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_out,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT =
    (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t state, next_state;

  logic [3:0]            cnt;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           wdata;

  logic                  req;
  logic                  cur_wr;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_re;
  logic                  unused_addr;

  assign req    = mem_r | mem_w;
  assign in_idx = mem_addr[ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];

  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+WORD_SHIFT],
                         mem_addr[WORD_SHIFT-1:0]};

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:
        if (req)
          next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt == 4'd0) next_state = S_RESP;
      S_RESP:
        next_state = S_IDLE;
      default:
        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req) begin
        op_wr <= mem_w;
        idx   <= in_idx;
        wdata <= mem_data_out;
        cnt   <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // With LATENCY=1 the RAM read happens on the accept edge itself,
  // so the live request drives the RAM until the latches are valid.
  assign cur_wr   = (state == S_IDLE) ? mem_w  : op_wr;
  assign ram_addr = (state == S_IDLE) ? in_idx : idx;

  assign ram_re = (state != S_RESP) && (next_state == S_RESP) && !cur_wr;
  assign ram_we = (state == S_RESP) && op_wr;

  mem_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (mem_data)
  );

  assign mem_ready = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder.
// Two instances: LATENCY=4 (a) and LATENCY=1 (b).
module tb_l2_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_r, a_w, a_rdy, a_busy;
  logic [31:0] a_addr, a_wd, a_data;
  logic        b_r, b_w, b_rdy, b_busy;
  logic [31:0] b_addr, b_wd, b_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  l2_mem_responder #(
    .ADDR_WIDTH (12),
    .LATENCY    (4),
    .INIT_FILE  ("")
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .mem_r        (a_r),
    .mem_w        (a_w),
    .mem_addr     (a_addr),
    .mem_data_out (a_wd),
    .mem_data     (a_data),
    .mem_ready    (a_rdy),
    .busy         (a_busy)
  );

  l2_mem_responder #(
    .ADDR_WIDTH (12),
    .LATENCY    (1),
    .INIT_FILE  ("")
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .mem_r        (b_r),
    .mem_w        (b_w),
    .mem_addr     (b_addr),
    .mem_data_out (b_wd),
    .mem_data     (b_data),
    .mem_ready    (b_rdy),
    .busy         (b_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, w,
                       input logic [31:0] addr, wd);
    if (sel) begin
      b_r = r; b_w = w; b_addr = addr; b_wd = wd;
    end else begin
      a_r = r; a_w = w; a_addr = addr; a_wd = wd;
    end
  endtask

  // Called #1 after a posedge: that cycle is T. Returns the number
  // of cycles until mem_ready and the data seen in the ready cycle.
  task automatic xfer(input bit sel, input logic r, w,
                      input logic [31:0] addr, wd,
                      output int lat, output logic [31:0] rd);
    logic rdy;
    lat = 0;
    drive(sel, r, w, addr, wd);
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? b_rdy : a_rdy;
    end while (!rdy && lat < 20);
    rd = sel ? b_data : a_data;
    rdy_cyc = cyc;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle1;
    @(posedge clk); #1;
  endtask

  int          lat;
  int          prev;
  logic [31:0] rd;
  logic [31:0] line_addr [4];
  logic [31:0] line_data [4];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    line_addr = '{32'h300, 32'h304, 32'h308, 32'h30C};
    line_data = '{32'h11110000, 32'h22220001,
                  32'h33330002, 32'h44440003};

    #1;
    check("rst_ready", {31'h0, a_rdy}, 32'h0);
    check("rst_busy", {31'h0, a_busy}, 32'h0);
    check("rst_data", a_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle1();

    // Read latency
    xfer(1'b0, 1'b0, 1'b1, 32'h100, 32'hCAFE0001, lat, rd);
    check("wr100_lat", lat, 4);
    idle1();
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    idle1();
    check("busy_wait", {31'h0, a_busy}, 32'h1);
    check("rdy_wait", {31'h0, a_rdy}, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, lat, rd);
    check("rd100_lat", lat + 1, 4);
    check("rd100_data", rd, 32'hCAFE0001);
    idle1();
    check("rdy_after", {31'h0, a_rdy}, 32'h0);
    check("busy_after", {31'h0, a_busy}, 32'h0);
    check("rd100_hold", a_data, 32'hCAFE0001);

    // Write then read back, low address bits ignored
    xfer(1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, lat, rd);
    check("wr200_lat", lat, 4);
    check("wr200_keep", rd, 32'hCAFE0001);
    idle1();
    xfer(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, lat, rd);
    check("rd200_data", rd, 32'h12345678);
    idle1();
    xfer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, lat, rd);
    check("no_req_idle", lat, 20);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle1();
    a_data_check_prev: begin end
    xfer(1'b0, 1'b1, 1'b0, 32'h202, 32'h0, lat, rd);
    check("rd202_data", rd, 32'h12345678);
    idle1();

    // Line fill, back-to-back requests
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b0, 1'b1, line_addr[i], line_data[i], lat, rd);
      idle1();
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b1, 1'b0, line_addr[i], 32'h0, lat, rd);
      check($sformatf("fill%0d_data", i), rd, line_data[i]);
      check($sformatf("fill%0d_lat", i), lat, 4);
      if (i > 0)
        check($sformatf("fill%0d_gap", i), rdy_cyc - prev, 5);
      prev = rdy_cyc;
      idle1();
    end

    // r and w both high: write, no read data
    xfer(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, lat, rd);
    idle1();
    xfer(1'b0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, lat, rd);
    check("rw_lat", lat, 4);
    check("rw_keep", rd, 32'h12345678);
    idle1();
    check("rw_keep2", a_data, 32'h12345678);
    xfer(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
    check("rw_rdback", rd, 32'hA5A5A5A5);
    idle1();

    // Reset during a write aborts it
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'h11112222, lat, rd);
    idle1();
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFF0000);
    idle1();
    idle1();
    rst = 1'b0;
    #1;
    check("abort_busy", {31'h0, a_busy}, 32'h0);
    check("abort_data", a_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle1();
      check($sformatf("abort_rdy%0d", i), {31'h0, a_rdy}, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) rst = 1'b1;
    idle1();
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd);
    check("abort_lat", lat, 4);
    check("abort_orig", rd, 32'h11112222);
    idle1();

    // LATENCY=1 and address wrap
    xfer(1'b1, 1'b0, 1'b1, 32'h00004004, 32'hDEADBEEF, lat, rd);
    check("l1_wr_lat", lat, 1);
    idle1();
    check("l1_rdy_low", {31'h0, b_rdy}, 32'h0);
    xfer(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, lat, rd);
    check("l1_rd_lat", lat, 1);
    check("l1_wrap", rd, 32'hDEADBEEF);
    idle1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
